mba_seq_multiplier: RTL and testbench

Parametrised, sequential radix-4 modified-Booth multiplier. It is the next generation of the fixed-width MBA multiplier driven into the user GPIO pads. Operand width is now a parameter, signed and unsigned operation are selectable per operation, and a start/busy/done handshake is added. It sits inside the user project wrapper, clocked from the Wishbone clock, and its product and output-enable buses drive a contiguous GPIO slice.

---
 rtl/mba_pkg.sv | 22 ++
 rtl/booth_r4_encoder.sv | 49 ++++
 rtl/mba_seq_multiplier.sv | 98 +++++++++
 tb/tb_mba_seq_multiplier.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mba_pkg.sv
// Shared types and helpers for the radix-4 modified-Booth sequential multiplier.
package mba_pkg;

   typedef enum logic {
      IDLE,
      CALC
   } state_t;

   typedef enum logic [2:0] {
      ZERO,
      POS1,
      POS2,
      NEG1,
      NEG2
   } digit_t;

   // Number of radix-4 digits needed; unsigned needs one extra non-negative top digit.
   function automatic int unsigned booth_digits(input int unsigned width, input logic signed_mode);
      return signed_mode ? (width / 32'd2) : (width / 32'd2 + 32'd1);
   endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth digit encoder: maps a 3-bit multiplier window to a partial product and negate flag.
module booth_r4_encoder
   import mba_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [2:0]       win,
   input  logic [WIDTH:0]   mcand,
   output logic [WIDTH+1:0] pp_c,
   output logic             neg_c
);

   digit_t digit;

   // Classify the window {b[2i+1], b[2i], b[2i-1]} into a Booth digit.
   always_comb begin
      digit = ZERO;
      case (win)
         3'b001, 3'b010: digit = POS1;
         3'b011:         digit = POS2;
         3'b100:         digit = NEG2;
         3'b101, 3'b110: digit = NEG1;
         default:        digit = ZERO;
      endcase
   end

   // Select |digit| * A; the negation itself is folded into the accumulator adder.
   always_comb begin
      pp_c  = '0;
      neg_c = 1'b0;
      case (digit)
         POS1: pp_c = {mcand[WIDTH], mcand};
         POS2: pp_c = {mcand, 1'b0};
         NEG1: begin
            pp_c  = {mcand[WIDTH], mcand};
            neg_c = 1'b1;
         end
         NEG2: begin
            pp_c  = {mcand, 1'b0};
            neg_c = 1'b1;
         end
         default: begin
            pp_c  = '0;
            neg_c = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mba_seq_multiplier.sv
// Sequential radix-4 modified-Booth multiplier, one digit per cycle, signed or unsigned per operation.
module mba_seq_multiplier #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   p,
   output logic [2*WIDTH-1:0]   io_oeb
);
   import mba_pkg::*;

   localparam int unsigned ACC_W = 2 * WIDTH + 2;
   localparam int unsigned BSH_W = WIDTH + 3;
   localparam int unsigned CNT_W = $clog2(WIDTH / 2 + 2);

   state_t           state;
   logic [WIDTH:0]   a_q;     // multiplicand extended by one bit
   logic [BSH_W-1:0] b_q;     // {extended multiplier, b[-1]}, shifted right two bits per digit
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] idx;

   logic [WIDTH+1:0] pp;
   logic             neg;
   logic [ACC_W-1:0] pp_ext;
   logic [ACC_W-1:0] term;
   logic [ACC_W-1:0] addend;
   logic [ACC_W-1:0] acc_nxt;

   booth_r4_encoder #(
      .WIDTH (WIDTH)
   ) u_enc (
      .win   (b_q[2:0]),
      .mcand (a_q),
      .pp_c  (pp),
      .neg_c (neg)
   );

   // Align the partial product to digit position and add it; -X is ~X + 1 via the carry-in.
   always_comb begin
      pp_ext  = {{WIDTH{pp[WIDTH+1]}}, pp};
      term    = pp_ext << {idx, 1'b0};
      addend  = neg ? ~term : term;
      acc_nxt = acc + addend + ACC_W'(neg);
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         p      <= '0;
         acc    <= '0;
         cnt    <= '0;
         idx    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         io_oeb <= '1;
      end else begin
         io_oeb <= '0;
         done   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= {a[WIDTH-1] & signed_mode, a};
                  b_q   <= {{2{b[WIDTH-1] & signed_mode}}, b, 1'b0};
                  acc   <= '0;
                  cnt   <= CNT_W'(booth_digits(WIDTH, signed_mode) - 32'd1);
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= acc_nxt;
               b_q <= b_q >> 2;
               idx <= idx + CNT_W'(1);
               cnt <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  p     <= acc_nxt[2*WIDTH-1:0];
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mba_seq_multiplier.sv
// Self-checking bench for mba_seq_multiplier at WIDTH=8 and WIDTH=16.
module tb_mba_seq_multiplier;

   logic        clk = 1'b0;
   logic        reset;

   logic        start8, sm8;
   logic [7:0]  a8, b8;
   logic        busy8, done8;
   logic [15:0] p8, oeb8;

   logic        start16, sm16;
   logic [15:0] a16, b16;
   logic        busy16, done16;
   logic [31:0] p16, oeb16;

   int checks   = 0;
   int failures = 0;
   int done_cnt8 = 0;
   int done_cnt16 = 0;

   logic [15:0] q8[$];
   logic [31:0] q16[$];

   always #5 clk = ~clk;

   mba_seq_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8), .io_oeb(oeb8)
   );

   mba_seq_multiplier #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .signed_mode(sm16),
      .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16), .io_oeb(oeb16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: multiply the operands extended to the product width, truncated.
   function automatic logic [15:0] ref8(input logic sm, input logic [7:0] x, input logic [7:0] y);
      logic [15:0] xe, ye;
      xe = {{8{sm & x[7]}}, x};
      ye = {{8{sm & y[7]}}, y};
      return 16'(xe * ye);
   endfunction

   function automatic logic [31:0] ref16(input logic sm, input logic [15:0] x, input logic [15:0] y);
      logic [31:0] xe, ye;
      xe = {{16{sm & x[15]}}, x};
      ye = {{16{sm & y[15]}}, y};
      return 32'(xe * ye);
   endfunction

   // Scoreboard: every done pulse pops one expected product.
   always @(negedge clk) begin
      if (!reset && done8) begin
         done_cnt8++;
         if (q8.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb8_unexpected_done observed=%0h expected=none", p8);
         end else begin
            chk("sb8_p", 32'(p8), 32'(q8.pop_front()));
         end
      end
      if (!reset && done16) begin
         done_cnt16++;
         if (q16.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb16_unexpected_done observed=%0h expected=none", p16);
         end else begin
            chk("sb16_p", p16, q16.pop_front());
         end
      end
   end

   task automatic wait_done8(input int max, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done8 && n < max);
   endtask

   task automatic wait_done16(input int max, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done16 && n < max);
   endtask

   task automatic run8(input logic sm, input logic [7:0] av, input logic [7:0] bv, input string tag);
      int n, lat;
      lat = sm ? 4 : 5;
      q8.push_back(ref8(sm, av, bv));
      sm8 = sm; a8 = av; b8 = bv; start8 = 1'b1;
      @(posedge clk); #1 start8 = 1'b0;
      chk({tag, "_busy"}, 32'(busy8), 32'd1);
      wait_done8(lat + 4, n);
      chk({tag, "_lat"}, 32'(n), 32'(lat));
   endtask

   task automatic run16(input logic sm, input logic [15:0] av, input logic [15:0] bv, input string tag);
      int n, lat;
      lat = sm ? 8 : 9;
      q16.push_back(ref16(sm, av, bv));
      sm16 = sm; a16 = av; b16 = bv; start16 = 1'b1;
      @(posedge clk); #1 start16 = 1'b0;
      chk({tag, "_busy"}, 32'(busy16), 32'd1);
      wait_done16(lat + 4, n);
      chk({tag, "_lat"}, 32'(n), 32'(lat));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, dc;
      reset = 1'b1;
      start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
      start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_oeb8", 32'(oeb8), 32'h0000_FFFF);
      chk("rst_oeb16", oeb16, 32'hFFFF_FFFF);
      chk("rst_busy8", 32'(busy8), 32'd0);
      chk("rst_done8", 32'(done8), 32'd0);
      chk("rst_p8", 32'(p8), 32'd0);
      chk("rst_p16", p16, 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      chk("oeb8_after_rst", 32'(oeb8), 32'd0);
      chk("oeb16_after_rst", oeb16, 32'd0);

      // Directed WIDTH=8 corners
      run8(1'b1, 8'h07, 8'hFD, "s7xm3");
      chk("p_s7xm3", 32'(p8), 32'h0000_FFEB);
      run8(1'b1, 8'h80, 8'h80, "s80x80");
      chk("p_s80x80", 32'(p8), 32'h0000_4000);
      run8(1'b0, 8'hFF, 8'hFF, "uFFxFF");
      chk("p_uFFxFF", 32'(p8), 32'h0000_FE01);
      chk("idle_busy", 32'(busy8), 32'd0);

      // start while busy is ignored
      q8.push_back(ref8(1'b1, 8'h07, 8'h05));
      sm8 = 1'b1; a8 = 8'h07; b8 = 8'h05; start8 = 1'b1;
      @(posedge clk); #1 start8 = 1'b0;
      dc = done_cnt8;
      @(posedge clk); #1;
      a8 = 8'h02; b8 = 8'h03; start8 = 1'b1;
      @(posedge clk); #1 start8 = 1'b0;
      chk("ign_busy", 32'(busy8), 32'd1);
      wait_done8(8, n);
      chk("ign_lat", 32'(n), 32'd2);
      chk("ign_p", 32'(p8), 32'h0000_0023);
      repeat (8) @(posedge clk);
      #1;
      chk("ign_one_done", 32'(done_cnt8 - dc), 32'd1);
      chk("ign_idle", 32'(busy8), 32'd0);

      // Reset mid-operation abandons it
      sm8 = 1'b1; a8 = 8'h09; b8 = 8'h09; start8 = 1'b1;
      @(posedge clk); #1 start8 = 1'b0;
      dc = done_cnt8;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", 32'(busy8), 32'd0);
      chk("midrst_done", 32'(done8), 32'd0);
      chk("midrst_p", 32'(p8), 32'd0);
      chk("midrst_oeb", 32'(oeb8), 32'h0000_FFFF);
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_no_done", 32'(done_cnt8 - dc), 32'd0);
      chk("midrst_oeb_low", 32'(oeb8), 32'd0);
      run8(1'b1, 8'h05, 8'h06, "s5x6");
      chk("p_s5x6", 32'(p8), 32'h0000_001E);

      // start held through done: back-to-back without an idle cycle
      q8.push_back(ref8(1'b1, 8'h07, 8'h05));
      sm8 = 1'b1; a8 = 8'h07; b8 = 8'h05; start8 = 1'b1;
      @(posedge clk); #1;
      a8 = 8'h03; b8 = 8'h04;
      wait_done8(8, n);
      chk("b2b_lat1", 32'(n), 32'd4);
      chk("b2b_p1", 32'(p8), 32'h0000_0023);
      q8.push_back(ref8(1'b1, 8'h03, 8'h04));
      @(posedge clk); #1 start8 = 1'b0;
      chk("b2b_busy", 32'(busy8), 32'd1);
      chk("b2b_p_hold", 32'(p8), 32'h0000_0023);
      wait_done8(8, n);
      chk("b2b_lat2", 32'(n), 32'd4);
      chk("b2b_p2", 32'(p8), 32'h0000_000C);

      // WIDTH=16 corners
      run16(1'b1, 16'h8000, 16'h8000, "s16_min");
      chk("p16_min", p16, 32'h4000_0000);
      run16(1'b0, 16'hFFFF, 16'hFFFF, "u16_max");
      chk("p16_max", p16, 32'hFFFE_0001);
      run16(1'b1, 16'hFFFF, 16'h7FFF, "s16_m1");
      chk("p16_m1", p16, 32'hFFFF_8001);

      // Randomised sweep
      for (int i = 0; i < 24; i++)
         run8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), "rnd8");
      for (int i = 0; i < 24; i++)
         run16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), "rnd16");

      repeat (3) @(posedge clk);
      #1;
      chk("sb8_drained", 32'(q8.size()), 32'd0);
      chk("sb16_drained", 32'(q16.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
